// File: rtl/rv32_mem_pkg.sv
// Shared RV32I memory-stage definitions: funct3 codes, FSM states,
// latched request record and small decode helpers.
package rv32_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width/sign code and byte offset captured when the access starts.
    typedef struct packed {
        logic [2:0] funct3;
        logic [1:0] offset;
    } req_t;

    // 011, 110 and 111 are not load/store widths.
    function automatic logic f3_legal(input logic [2:0] f3);
        return !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data extraction: picks the addressed byte/halfword out of the bus
// word and sign- or zero-extends it according to funct3.
module load_align
    import rv32_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    // Select the lane, then extend per load type; unknown codes read as 0.
    always_comb begin
        b    = 8'(rdata >> {offset, 3'b000});
        h    = offset[1] ? rdata[31:16] : rdata[15:0];
        data = 32'b0;
        case (funct3)
            F3_LB:   data = {{24{b[7]}}, b};
            F3_LH:   data = {{16{h[15]}}, h};
            F3_LW:   data = rdata;
            F3_LBU:  data = {24'b0, b};
            F3_LHU:  data = {16'b0, h};
            default: data = 32'b0;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I memory stage: req/ready data-bus handshake, byte enables and store
// lane placement, load alignment, pipeline stall and a bus watchdog.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses are not issued and
// raise misalign_err instead.
module mem_access_stage
    import rv32_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] write_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] read_data,
    output logic        mem_stall,
    output logic        bus_err,
    output logic        misalign_err
);

    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] wd_cnt;
    logic [31:0]      rdata_q;
    req_t             req_q;
    logic             bus_err_q;
    logic             start;
    logic             trap;
    logic [3:0]       be;
    logic [31:0]      wdata;
    logic [31:0]      aligned;

    // A legal access in IDLE starts a transaction; reset gates it so the
    // request drops immediately when reset is asserted.
    assign start = (state == IDLE) && (mem_read || mem_write) && !reset && f3_legal(funct3);

`ifdef MEM_MISALIGN_TRAP_EN
    logic mis_q;
    assign trap         = f3_misaligned(funct3, alu_result[1:0]);
    assign misalign_err = mis_q;
`else
    assign trap         = 1'b0;
    assign misalign_err = 1'b0;
`endif

    assign dmem_req   = (start && !trap) || (state == WAIT);
    assign mem_stall  = start || (state == WAIT);
    assign dmem_we    = dmem_req && mem_write;
    assign dmem_addr  = dmem_req ? {alu_result[31:2], 2'b00} : 32'b0;
    assign dmem_be    = dmem_req ? be : 4'b0;
    assign dmem_wdata = dmem_req ? wdata : 32'b0;
    assign bus_err    = bus_err_q;
    assign read_data  = (state == DONE) ? aligned : 32'b0;

    // Byte-enable mask and lane-replicated store data from width and offset.
    always_comb begin
        be    = 4'b1111;
        wdata = write_data;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << alu_result[1:0];
                wdata = {4{write_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << {alu_result[1], 1'b0};
                wdata = {2{write_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = write_data;
            end
        endcase
    end

    load_align u_load_align (
        .rdata  (rdata_q),
        .offset (req_q.offset),
        .funct3 (req_q.funct3),
        .data   (aligned)
    );

    // Transaction FSM with watchdog; error flags are single-cycle pulses seen in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wd_cnt    <= '0;
            rdata_q   <= 32'b0;
            req_q     <= '0;
            bus_err_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q     <= 1'b0;
`endif
        end else begin
            bus_err_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q     <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (start) begin
                        req_q.funct3 <= funct3;
                        req_q.offset <= alu_result[1:0];
                        if (trap) begin
                            rdata_q <= 32'b0;
`ifdef MEM_MISALIGN_TRAP_EN
                            mis_q   <= 1'b1;
`endif
                            state   <= DONE;
                        end else if (dmem_ready) begin
                            rdata_q <= dmem_rdata;
                            state   <= DONE;
                        end else begin
                            state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_ready) begin
                        rdata_q <= dmem_rdata;
                        wd_cnt  <= '0;
                        state   <= DONE;
                    end else if (wd_cnt == WD_LIMIT) begin
                        bus_err_q <= 1'b1;
                        rdata_q   <= 32'b0;
                        wd_cnt    <= '0;
                        state     <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                DONE: begin
                    wd_cnt <= '0;
                    state  <= IDLE;
                end
                default: begin
                    wd_cnt <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized
// accesses compared against a behavioural model of the memory stage.
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_result, write_data;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic [31:0] read_data;
    logic        mem_stall, bus_err, misalign_err;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .alu_result   (alu_result),
        .write_data   (write_data),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_ready   (dmem_ready),
        .dmem_rdata   (dmem_rdata),
        .read_data    (read_data),
        .mem_stall    (mem_stall),
        .bus_err      (bus_err),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---- behavioural model ----
    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] f3);
        logic [31:0] bsh, hsh;
        bsh = w >> (8 * int'(off));
        hsh = w >> (16 * int'(off[1]));
        case (f3)
            3'b000:  return 32'($signed(bsh[7:0]));
            3'b001:  return 32'($signed(hsh[15:0]));
            3'b010:  return w;
            3'b100:  return bsh & 32'hFF;
            3'b101:  return hsh & 32'hFFFF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'(1 << off);
            2'b01:   return 4'(3 << (off & 2'b10));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return (wd & 32'hFF) * 32'h01010101;
            2'b01:   return (wd & 32'hFFFF) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    function automatic bit m_mis(input logic [2:0] f3, input logic [1:0] off);
        if (f3[1:0] == 2'b01) return off[0];
        if (f3[1:0] == 2'b10) return off != 0;
        return 1'b0;
    endfunction

    // One instruction through MEM; ready arrives on stall cycle k (0 = first).
    task automatic run(input string nm, input bit mr, input bit mw, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                       input int k);
        bit legal, acc, trap, tmo;
        int exp_stall, stall;
        logic [31:0] exp_rd;
        legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        acc   = (mr || mw) && legal;
        trap  = acc && TRAP_EN && m_mis(f3, a[1:0]);
        tmo   = acc && !trap && (k > TO);
        exp_stall = !acc ? 0 : trap ? 1 : tmo ? TO + 1 : k + 1;
        exp_rd    = (acc && mr && !trap && !tmo) ? m_load(rd, a[1:0], f3) : 32'h0;

        @(posedge clk); #1;
        mem_read = mr; mem_write = mw; funct3 = f3; alu_result = a;
        write_data = wd; dmem_rdata = rd; dmem_ready = (k == 0);
        stall = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!mem_stall) break;
            chk({nm, ".req"}, 32'(dmem_req), 32'(!trap));
            if (!trap) begin
                chk({nm, ".addr"}, dmem_addr, {a[31:2], 2'b00});
                if (c == 0) begin
                    chk({nm, ".we"}, 32'(dmem_we), 32'(mw));
                    if (mw) begin
                        chk({nm, ".be"}, 32'(dmem_be), 32'(m_be(f3, a[1:0])));
                        chk({nm, ".wdata"}, dmem_wdata, m_wdata(f3, wd));
                    end
                end
            end
            stall++;
            @(posedge clk); #1;
            dmem_ready = (c + 1 == k);
        end
        chk({nm, ".stall"}, 32'(stall), 32'(exp_stall));
        if (acc) chk({nm, ".done_req"}, 32'(dmem_req), 32'h0);
        if (mr) chk({nm, ".rdata"}, read_data, exp_rd);
        chk({nm, ".bus_err"}, 32'(bus_err), 32'(tmo));
        chk({nm, ".mis_err"}, 32'(misalign_err), 32'(trap));
        @(posedge clk); #1;
        mem_read = 0; mem_write = 0; dmem_ready = 0;
        @(negedge clk);
        chk({nm, ".idle_stall"}, 32'(mem_stall), 32'h0);
        chk({nm, ".idle_rd"}, read_data, 32'h0);
        chk({nm, ".idle_err"}, 32'({bus_err, misalign_err}), 32'h0);
    endtask

    initial begin
        reset = 1; mem_read = 0; mem_write = 0; funct3 = 0; alu_result = 0;
        write_data = 0; dmem_ready = 0; dmem_rdata = 0;
        #1;
        chk("rst.req",   32'(dmem_req), 32'h0);
        chk("rst.stall", 32'(mem_stall), 32'h0);
        chk("rst.rd",    read_data, 32'h0);
        chk("rst.err",   32'({bus_err, misalign_err}), 32'h0);
        repeat (2) @(negedge clk);
        reset = 0;

        run("lw_fast",  1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0);
        run("lb_ws3",   1, 0, 3'b000, 32'h103, 0, 32'h80112233, 3);
        run("lhu",      1, 0, 3'b101, 32'h102, 0, 32'h80112233, 1);
        run("sh",       0, 1, 3'b001, 32'h206, 32'h1234ABCD, 0, 0);
        run("timeout",  1, 0, 3'b010, 32'h300, 0, 32'hCAFEF00D, 100);
        run("lw_mis",   1, 0, 3'b010, 32'h101, 0, 32'h11223344, 0);
        run("nop",      0, 0, 3'b010, 32'h100, 0, 32'h55555555, 0);
        run("illegal",  1, 0, 3'b011, 32'h100, 0, 32'h55555555, 0);

        // Reset asserted while waiting on the bus.
        @(posedge clk); #1;
        mem_read = 1; funct3 = 3'b010; alu_result = 32'h400; dmem_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rstw.pre_req", 32'(dmem_req), 32'h1);
        reset = 1; mem_read = 0;
        #1;
        chk("rstw.async_req", 32'(dmem_req), 32'h0);
        @(negedge clk);
        chk("rstw.req",   32'(dmem_req), 32'h0);
        chk("rstw.stall", 32'(mem_stall), 32'h0);
        reset = 0;
        run("post_rst", 1, 0, 3'b100, 32'h401, 0, 32'h0000A500, 0);

        // Randomized mix of loads, stores, nops and illegal codes.
        for (int i = 0; i < 80; i++) begin
            int kind, kk;
            logic [2:0] f3;
            bit mr, mw;
            kind = $urandom_range(0, 9);
            mr = 0; mw = 0;
            if (kind < 5) begin
                mr = 1;
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010;
                    3: f3 = 3'b100; default: f3 = 3'b101;
                endcase
            end else if (kind < 8) begin
                mw = 1; f3 = 3'($urandom_range(0, 2));
            end else if (kind == 8) begin
                mr = 1;
                case ($urandom_range(0, 2))
                    0: f3 = 3'b011; 1: f3 = 3'b110; default: f3 = 3'b111;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            kk = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, TO);
            run("rand", mr, mw, f3, $urandom, $urandom, $urandom, kk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
